// File: rtl/riscy_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package riscy_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EXT  = 2'd2,
    ST_WR   = 2'd3
  } lsu_state_t;

  // Size 3 is never legal, so it is folded into the misalignment test.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: little-endian extraction with sign/zero extension
// for loads, and lane merge of right-aligned store data into a RAM word.
module lsu_lane
  import riscy_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_byte = i_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

  function automatic logic [31:0] extend_byte(input logic signed [7:0] v, input logic zext);
    logic signed [31:0] s;
    s = 32'(v);
    return zext ? {24'd0, v} : s;
  endfunction

  function automatic logic [31:0] extend_half(input logic signed [15:0] v, input logic zext);
    logic signed [31:0] s;
    s = 32'(v);
    return zext ? {16'd0, v} : s;
  endfunction

  always_comb begin
    o_rdata = i_word;
    case (i_size)
      SZ_B:    o_rdata = extend_byte(w_byte, i_unsigned);
      SZ_H:    o_rdata = extend_half(w_half, i_unsigned);
      default: o_rdata = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_B:    o_merged[{i_lane, 3'b000} +: 8]    = i_wdata[7:0];
      SZ_H:    o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a synchronous word RAM: word stores write
// directly, loads read then extract, sub-word stores read-modify-write.
module lsu
  import riscy_mem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW+1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [31:0]   resp_rdata,
  output logic          ram_write,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_data,
  input  logic [31:0]   ram_out
);

  lsu_state_t    r_state, w_state_nxt;
  logic          r_ram_write, w_ram_write_nxt;
  logic [AW-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [31:0]   r_ram_data, w_ram_data_nxt;
  logic          r_resp_valid, w_resp_valid_nxt;
  logic          r_resp_err, w_resp_err_nxt;
  logic [31:0]   r_resp_rdata, w_resp_rdata_nxt;

  logic [1:0]    r_size, r_lane;
  logic          r_unsigned, r_write;
  logic [31:0]   r_wdata;

  logic          w_accept;
  logic [31:0]   w_ext_rdata, w_merged;

  assign req_ready  = (r_state == ST_IDLE);
  assign w_accept   = req_valid && req_ready;

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign ram_write  = r_ram_write;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;

  lsu_lane u_lane (
    .i_word     (ram_out),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_rdata    (w_ext_rdata),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_ram_write_nxt  = 1'b0;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_data_nxt   = r_ram_data;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = 32'd0;
          end else if (req_write && (req_size == SZ_W)) begin
            w_ram_addr_nxt  = req_addr[AW+1:2];
            w_ram_data_nxt  = req_wdata;
            w_ram_write_nxt = 1'b1;
            w_state_nxt     = ST_WR;
          end else begin
            w_ram_addr_nxt  = req_addr[AW+1:2];
            w_state_nxt     = ST_RD;
          end
        end
      end
      ST_RD: w_state_nxt = ST_EXT;
      ST_EXT: begin
        // ram_out now holds the addressed word; either merge it or return it.
        if (r_write) begin
          w_ram_data_nxt  = w_merged;
          w_ram_write_nxt = 1'b1;
          w_state_nxt     = ST_WR;
        end else begin
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = w_ext_rdata;
          w_state_nxt      = ST_IDLE;
        end
      end
      ST_WR: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = 32'd0;
        w_state_nxt      = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stage boundary: FSM state and all externally visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ram_write  <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ram_write  <= w_ram_write_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_data   <= w_ram_data_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
    end
  end

  // Stage boundary: request fields held for the duration of the access.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_wdata    <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a reference memory predicts each response, which
// is checked for data, error flag, latency and RAM write pulses.
module tb_lsu;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'd0;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic [31:0]   ram_out;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          acc;
  } sb_item_t;

  sb_item_t sb[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wr_cnt = 0, tot_wr = 0, tot_resp = 0;
  bit mon_en = 0, b2b_mode = 0, b2b_first = 0;

  always #5 clk = ~clk;

  lsu #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_out(ram_out)
  );

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_data;
    else           ram_out <= mem[ram_addr];
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic sb_item_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                     input logic [AW+1:0] a, input logic [31:0] wd);
    sb_item_t it;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    it.err = 1'b0; it.rdata = 32'd0; it.lat = 0; it.nwr = 0; it.acc = 0;
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) begin
      it.err = 1'b1;
      return it;
    end
    w = ref_mem[a[AW+1:2]];
    if (wr) begin
      it.nwr = 1;
      it.lat = (sz == 2'd2) ? 1 : 3;
      case (sz)
        2'd0:    w[8*int'(a[1:0]) +: 8] = wd[7:0];
        2'd1:    w[16*int'(a[1]) +: 16] = wd[15:0];
        default: w = wd;
      endcase
      ref_mem[a[AW+1:2]] = w;
    end else begin
      it.lat = 2;
      b = 8'(w >> (8 * int'(a[1:0])));
      h = 16'(w >> (16 * int'(a[1])));
      case (sz)
        2'd0:    it.rdata = uns ? {24'd0, b} : {{24{b[7]}}, b};
        2'd1:    it.rdata = uns ? {16'd0, h} : {{16{h[15]}}, h};
        default: it.rdata = w;
      endcase
    end
    return it;
  endfunction

  // Monitor: counts RAM write pulses between responses and scores each response.
  always @(negedge clk) begin
    sb_item_t it;
    cyc = cyc + 1;
    if (mon_en) begin
      if (ram_write === 1'b1) begin
        wr_cnt = wr_cnt + 1;
        tot_wr = tot_wr + 1;
      end
      if (resp_valid === 1'b1) begin
        tot_resp = tot_resp + 1;
        if (sb.size() == 0) begin
          chk_eq("unexpected_resp", 32'd1, 32'd0);
        end else begin
          it = sb.pop_front();
          chk_eq("rdata", resp_rdata, it.rdata);
          chk_eq("err", {31'd0, resp_err}, {31'd0, it.err});
          chk_eq("latency", 32'(cyc - it.acc - 1), 32'(it.lat));
          chk_eq("ram_write_cycles", 32'(wr_cnt), 32'(it.nwr));
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [AW+1:0] a, input logic [31:0] wd);
    sb_item_t it;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk_eq("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (b2b_mode && !b2b_first) chk_eq("b2b_accept_in_resp", {31'd0, resp_valid}, 32'd1);
    b2b_first = 0;
    @(posedge clk);
    it = model(wr, sz, uns, a, wd);
    it.acc = cyc;
    sb.push_back(it);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre_wr, pre_resp;
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk_eq("rst_resp_rdata", resp_rdata, 32'd0);
    chk_eq("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk_eq("rst_ram_data", ram_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    mon_en = 1;

    do_req(1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF); drain();
    do_req(1'b0, 2'd2, 1'b1, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd0, 1'b0, 14'h013, 32'd0);        drain();
    do_req(1'b0, 2'd0, 1'b1, 14'h013, 32'd0);        drain();
    do_req(1'b0, 2'd0, 1'b0, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd0, 1'b0, 14'h011, 32'd0);        drain();
    do_req(1'b1, 2'd1, 1'b0, 14'h012, 32'hFFFF1234); drain();
    do_req(1'b0, 2'd2, 1'b0, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd1, 1'b0, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd1, 1'b1, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd1, 1'b0, 14'h012, 32'd0);        drain();
    do_req(1'b1, 2'd0, 1'b0, 14'h011, 32'h777777A5); drain();
    do_req(1'b0, 2'd2, 1'b0, 14'h010, 32'd0);        drain();

    do_req(1'b0, 2'd2, 1'b0, 14'h011, 32'd0);        drain();
    do_req(1'b0, 2'd3, 1'b0, 14'h010, 32'd0);        drain();
    do_req(1'b0, 2'd1, 1'b0, 14'h013, 32'd0);        drain();
    do_req(1'b1, 2'd2, 1'b0, 14'h012, 32'h0BADF00D); drain();
    do_req(1'b0, 2'd2, 1'b0, 14'h010, 32'd0);        drain();

    b2b_mode = 1; b2b_first = 1;
    do_req(1'b1, 2'd2, 1'b0, 14'h020, 32'h11223344);
    do_req(1'b0, 2'd0, 1'b1, 14'h022, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 14'h020, 32'd0);
    do_req(1'b1, 2'd1, 1'b0, 14'h020, 32'h0000BEEF);
    do_req(1'b0, 2'd2, 1'b0, 14'h020, 32'd0);
    do_req(1'b1, 2'd0, 1'b0, 14'h023, 32'h00000099);
    do_req(1'b0, 2'd2, 1'b0, 14'h020, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 14'h011, 32'd0);
    do_req(1'b0, 2'd0, 1'b0, 14'h023, 32'd0);
    drain();
    b2b_mode = 0;

    do_req(1'b1, 2'd2, 1'b0, 14'h030, 32'hCAFEF00D); drain();
    pre_wr = tot_wr;
    pre_resp = tot_resp;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 14'h031; req_wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk_eq("midrst_no_write", 32'(tot_wr), 32'(pre_wr));
    chk_eq("midrst_no_resp", 32'(tot_resp), 32'(pre_resp));
    chk_eq("midrst_ram_word", mem[12'h00C], 32'hCAFEF00D);
    do_req(1'b0, 2'd2, 1'b0, 14'h030, 32'd0);        drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter AW, default 12, meaning RAM word-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port req_valid, input, 1, CPU access request.
REQ-005 SHALL have port req_ready, output, 1, high when a request can be accepted.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 SHALL have port req_unsigned, input, 1, zero-extend loads when 1.
REQ-009 SHALL have port req_addr, input, AW+2, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_err, output, 1, qualifies resp_valid: misaligned or illegal access.
REQ-013 SHALL have port resp_rdata, output, 32, load result.
REQ-014 SHALL have ports ram_write (output, 1), ram_addr (output, AW), ram_data (output, 32) and ram_out (input, 32), driving the synchronous word RAM.

Function
REQ-015 SHALL assume the RAM contract: at each edge it writes if ram_write is high, and otherwise loads ram_out with the addressed word, giving 1-cycle read latency; ram_out is ignored while ram_write is high.
REQ-016 SHALL implement a 4-state FSM (IDLE, RD, EXT, WR) and drive req_ready = (state == IDLE).
REQ-017 SHALL accept a request at an edge E0 where req_valid and req_ready are both high, and latch the request fields at E0.
REQ-018 SHALL treat an access as misaligned when it is a half access with addr[0]=1, a word access with addr[1:0]≠0, or size=3.
REQ-019 SHALL, for a misaligned access, set resp_valid=1 and resp_err=1 at E0, stay in IDLE, and make no RAM access.
REQ-020 SHALL, for a word store, set ram_addr=addr[AW+1:2], ram_data=wdata and ram_write=1 at E0, go to WR, then at E1 set ram_write=0 and resp_valid=1 and return to IDLE.
REQ-021 SHALL, for a load, set ram_addr and ram_write=0 at E0 (RD), go to EXT at E1, and at E2 set resp_rdata to the extracted lane and resp_valid=1, returning to IDLE.
REQ-022 SHALL, for a byte or half store, use read-modify-write: RD at E0, EXT at E1, then at E2 drive ram_data = ram_out with only the addressed lane replaced and ram_write=1 (WR), and at E3 set ram_write=0 and resp_valid=1.
REQ-023 SHALL use little-endian lanes: byte k occupies bits [8k+7:8k] and half h occupies bits [16h+15:16h].
REQ-024 SHALL sign-extend loads from the lane MSB unless req_unsigned=1, and SHALL ignore req_unsigned for word loads.
REQ-025 SHALL, for each store, assert ram_write for exactly one cycle.
REQ-026 SHALL set resp_rdata=0 for stores and errors, and hold resp_rdata until the next response.
REQ-027 SHALL set resp_valid high for exactly one cycle per accepted request, and resp_err SHALL be 0 on non-error responses.
REQ-028 SHALL permit a new request to be accepted in the same cycle that resp_valid is high, i.e. back-to-back operation.
REQ-029 SHALL ignore requests while busy; no request is queued.

Reset
REQ-030 SHALL, while rst=1 at an edge, set state=IDLE, ram_write=0, ram_addr=0, ram_data=0, resp_valid=0, resp_err=0 and resp_rdata=0, with req_ready=1 from the next cycle.
REQ-031 SHALL abandon any in-flight operation on reset mid-operation: no response is issued and no RAM write is issued after reset is sampled.

Structure
REQ-032 SHALL place the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state encoding in the shared package riscy_mem_pkg.
REQ-033 SHALL place lane extract, sign extension and lane merge in the combinational sub-module lsu_lane.

Verification
REQ-034 SHALL cover a word store of 0xDEADBEEF to byte address 0x010, then a word load of 0x010 -> resp_rdata=0xDEADBEEF with resp_valid 2 edges after acceptance and resp_err=0.
REQ-035 SHALL cover a signed byte load of 0x013 from the same word -> 0xFFFFFFDE, and an unsigned byte load of 0x013 -> 0x000000DE.
REQ-036 SHALL cover a half store of 0x1234 to 0x012, then a word load of 0x010 -> 0x1234BEEF, with ram_write high for exactly one cycle and resp_valid 3 edges after acceptance.
REQ-037 SHALL cover a word load at 0x011 and a request with size=3 -> resp_err=1 at the first edge after acceptance, with ram_write never asserted.
REQ-038 SHALL cover back-to-back requests with req_valid held high -> each accepted in the cycle where resp_valid=1, with no lost response.
REQ-039 SHALL cover rst asserted in the EXT state of a byte store -> no ram_write, no resp_valid, and RAM contents unchanged.
